posit_encoder: RTL
==================

POSIT_ENCODER -- requirements
Module: posit_encoder

Interface
REQ-001 Parameter N, default 32, total posit width in bits.
REQ-002 Parameter ES, default 2, exponent field width.
REQ-003 Parameter SCALE_W, default 10, signed scale input width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  source presents a decoded value.
REQ-007 in_ready  output  1  encoder accepts the value this cycle.
REQ-008 in_sign  input  1  value sign, 1 = negative.
REQ-009 in_zero  input  1  value is exact zero; overrides sign/scale/frac.
REQ-010 in_nar  input  1  value is NaR; overrides all other fields, including in_zero.
REQ-011 in_scale  input  SCALE_W  signed two's-complement power-of-two scale = k*2^ES + e.
REQ-012 in_frac  input  N-2  fraction bits after the hidden 1, MSB-aligned.
REQ-013 out_valid  output  1  out_posit holds an encoded result.
REQ-014 out_ready  input  1  sink accepts the result this cycle.
REQ-015 out_posit  output  N  encoded posit, two's complement when negative.

Function
REQ-016 Input transfer occurs when in_valid and in_ready are both high; output transfer occurs when out_valid and out_ready are both high.
REQ-017 Two-stage pipeline; latency from input transfer to out_valid is exactly 2 cycles with no stall.
REQ-018 Stage 1 registers: k = in_scale >>> ES (arithmetic); e = in_scale[ES-1:0]; special-case flags; saturation flags.
REQ-019 Stage 2 registers the encoded word.
REQ-020 Regime for k >= 0 is k+1 ones then a zero; for k < 0 it is -k zeros then a one.
REQ-021 Body (N-1 bits) is regime, then e, then in_frac, left-packed; bits beyond N-1 are truncated after rounding.
REQ-022 Rounding is round-to-nearest-even on the truncated bits: guard = first dropped bit, sticky = OR of the rest.
REQ-023 Rounding shall never produce zero or NaR: a nonzero result rounding to 0 yields minpos (body 0...01); a carry into the sign position yields maxpos (body 1...1).
REQ-024 in_scale > (N-2)*2^ES saturates to maxpos; in_scale < -(N-2)*2^ES saturates to minpos.
REQ-025 After rounding and saturation, a negative result is the two's complement of {0, body}.
REQ-026 in_zero yields all zeros; in_nar yields 1 followed by N-1 zeros; sign is ignored for both.
REQ-027 Each stage holds its contents while the downstream stage is occupied and not advancing.
REQ-028 in_ready = !s1_valid || (!s2_valid || out_ready); full throughput of 1 value/cycle when out_ready is held high.
REQ-029 out_posit and out_valid shall be stable while out_valid is high and out_ready is low.
REQ-030 Simultaneous input and output transfer in one cycle advances both stages without data loss.

Reset
REQ-031 rst_n low asynchronously clears both stage valid flags; out_valid = 0, in_ready = 1 during reset, out_posit = 0.
REQ-032 Data in flight when rst_n asserts is discarded; no output transfer follows reset release until a new input transfer.
REQ-033 Datapath registers other than valid flags and out_posit need not be reset.

Structure
REQ-034 Shared package posit_pkg holds N, ES, SCALE_W defaults, derived max scale (N-2)*2^ES, and the NAR, ZERO, MAXPOS and MINPOS bit-pattern constants, shared with the decoder.
REQ-035 Rounding logic (REQ-022/REQ-023) is a combinational sub-module posit_round_rne instantiated in stage 2.

Verification (N=32, ES=2)
REQ-036 scale=0, frac=0, sign=0 -> 0x40000000 two cycles later; sign=1 -> 0xC0000000.
REQ-037 scale=1 -> 0x48000000; scale=4 -> 0x60000000; zero -> 0x00000000; NaR -> 0x80000000.
REQ-038 scale=120 -> 0x7FFFFFFF; scale=200 -> 0x7FFFFFFF; scale=-121 -> 0x00000001; scale=-120 -> 0x00000001.
REQ-039 Rounding: scale=0, frac halfway with even LSB -> rounds down; same with sticky=1 -> rounds up by 1 ULP.
REQ-040 out_ready low for 3 cycles after 3 back-to-back inputs -> out_posit stable, in_ready low once both stages full, all 3 results delivered in order after release.
REQ-041 rst_n asserted with both stages full -> out_valid low immediately, in_ready high; no stale result after release.

Source files
------------

// File: rtl/posit_pkg.sv
// posit_pkg: shared posit format constants for the encoder and decoder.
//   POSIT_N / POSIT_ES / POSIT_SCALE_W : default width, exponent width and
//                                        signed scale width
//   POSIT_MAX_SCALE                    : largest scale magnitude that is
//                                        representable without saturating
//   POSIT_ZERO / POSIT_NAR /
//   POSIT_MAXPOS / POSIT_MINPOS        : special bit patterns at POSIT_N
//   max_scale()                        : (n-2)*2^es for other widths
package posit_pkg;

  localparam int POSIT_N       = 32;
  localparam int POSIT_ES      = 2;
  localparam int POSIT_SCALE_W = 10;

  localparam int POSIT_MAX_SCALE = (POSIT_N - 2) << POSIT_ES;

  localparam logic [POSIT_N-1:0] POSIT_ZERO   = '0;
  localparam logic [POSIT_N-1:0] POSIT_NAR    = {1'b1, {(POSIT_N-1){1'b0}}};
  localparam logic [POSIT_N-1:0] POSIT_MAXPOS = {1'b0, {(POSIT_N-1){1'b1}}};
  localparam logic [POSIT_N-1:0] POSIT_MINPOS = {{(POSIT_N-1){1'b0}}, 1'b1};

  function automatic int max_scale(input int n, input int es);
    return (n - 2) << es;
  endfunction

endpackage

// File: rtl/posit_round_rne.sv
// posit_round_rne: combinational round-to-nearest-even of a posit body.
//   body    : N-1 bit unsigned body before rounding (regime, exponent, fraction)
//   guard   : first bit dropped below body
//   sticky  : OR of all bits dropped below guard
//   rounded : N-1 bit body after rounding, never zero and never overflowing
//             into the sign position
module posit_round_rne #(
  parameter int N = 32
) (
  input  logic [N-2:0] body,
  input  logic         guard,
  input  logic         sticky,
  output logic [N-2:0] rounded
);

  logic         round_up;
  logic [N-1:0] sum;

  // A carry out of the body would land in the sign bit and read as NaR, so it
  // clamps to maxpos; a zero body would read as zero, so it clamps to minpos.
  always_comb begin
    round_up = guard & (sticky | body[0]);
    sum      = {1'b0, body} + {{(N-1){1'b0}}, round_up};
    if (sum[N-1]) begin
      rounded = {(N-1){1'b1}};
    end else if (sum[N-2:0] == '0) begin
      rounded = {{(N-2){1'b0}}, 1'b1};
    end else begin
      rounded = sum[N-2:0];
    end
  end

endmodule

// File: rtl/posit_encoder.sv
// posit_encoder: two-stage pipelined encoder from a decoded value
// (sign, scale, fraction, zero/NaR flags) to an N-bit posit.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : input handshake
//   in_sign              : 1 = negative
//   in_zero / in_nar     : special values (NaR wins over zero)
//   in_scale             : signed scale = k*2^ES + e
//   in_frac              : fraction after the hidden 1, MSB-aligned
//   out_valid / out_ready: output handshake
//   out_posit            : encoded posit
// Stage 1 splits the scale into regime k and exponent e and flags saturation;
// stage 2 builds, rounds, saturates and signs the word.
module posit_encoder
  import posit_pkg::*;
#(
  parameter int N       = POSIT_N,
  parameter int ES      = POSIT_ES,
  parameter int SCALE_W = POSIT_SCALE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sign,
  input  logic               in_zero,
  input  logic               in_nar,
  input  logic [SCALE_W-1:0] in_scale,
  input  logic [N-3:0]       in_frac,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out_posit
);

  localparam int KW = SCALE_W - ES;
  localparam int FW = N - 2;
  localparam int TW = ES + FW;
  // Room for the longest regime run plus terminator, exponent and fraction.
  localparam int LW = 2 * N + ES;

  localparam logic signed [SCALE_W-1:0] SAT_HI = SCALE_W'(max_scale(N, ES));
  localparam logic signed [SCALE_W-1:0] SAT_LO = SCALE_W'(-max_scale(N, ES));

  localparam logic [N-1:0] NAR_WORD  = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-2:0] MAXP_BODY = {(N-1){1'b1}};
  localparam logic [N-2:0] MINP_BODY = {{(N-2){1'b0}}, 1'b1};

  logic s1_valid;
  logic s2_valid;
  logic s2_advance;
  logic in_fire;

  logic signed [KW-1:0] s1_k;
  logic [ES-1:0]        s1_e;
  logic [FW-1:0]        s1_frac;
  logic                 s1_sign;
  logic                 s1_zero;
  logic                 s1_nar;
  logic                 s1_sat_max;
  logic                 s1_sat_min;

  logic signed [SCALE_W-1:0] scale_s;

  logic signed [KW:0] k_ext;
  logic [KW:0]        run;
  logic               term;
  logic [LW-1:0]      seed;
  logic [LW-1:0]      shifted;
  logic [N-2:0]       body;
  logic               guard;
  logic               sticky;
  logic [N-2:0]       rounded;
  logic [N-2:0]       final_body;
  logic [N-1:0]       pos_word;
  logic [N-1:0]       word;

  assign s2_advance = !s2_valid || out_ready;
  assign in_ready   = !s1_valid || s2_advance;
  assign in_fire    = in_valid && in_ready;
  assign out_valid  = s2_valid;
  assign scale_s    = in_scale;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      out_posit <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (s2_advance) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_posit <= word;
        end
      end
    end
  end

  // The upper scale bits are exactly floor(scale / 2^ES), i.e. scale >>> ES.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_k       <= in_scale[SCALE_W-1:ES];
      s1_e       <= in_scale[ES-1:0];
      s1_frac    <= in_frac;
      s1_sign    <= in_sign;
      s1_zero    <= in_zero;
      s1_nar     <= in_nar;
      s1_sat_max <= scale_s > SAT_HI;
      s1_sat_min <= scale_s < SAT_LO;
    end
  end

  // Regime as a run of identical bits ending in the opposite bit: the
  // terminator, exponent and fraction are shifted right by the run length,
  // with ones filled in for k >= 0 (done by shifting the complement).
  always_comb begin
    k_ext = {s1_k[KW-1], s1_k};
    if (s1_k[KW-1]) begin
      run  = ~$unsigned(k_ext) + {{KW{1'b0}}, 1'b1};
      term = 1'b1;
    end else begin
      run  = $unsigned(k_ext) + {{KW{1'b0}}, 1'b1};
      term = 1'b0;
    end
    seed = {term, s1_e, s1_frac, {(LW-1-TW){1'b0}}};
    if (s1_k[KW-1]) begin
      shifted = seed >> run;
    end else begin
      shifted = ~((~seed) >> run);
    end
    body   = shifted[LW-1 -: N-1];
    guard  = shifted[LW-N];
    sticky = |shifted[LW-N-1:0];
  end

  posit_round_rne #(.N(N)) u_round (
    .body    (body),
    .guard   (guard),
    .sticky  (sticky),
    .rounded (rounded)
  );

  always_comb begin
    if (s1_sat_max) begin
      final_body = MAXP_BODY;
    end else if (s1_sat_min) begin
      final_body = MINP_BODY;
    end else begin
      final_body = rounded;
    end
    pos_word = {1'b0, final_body};
    if (s1_nar) begin
      word = NAR_WORD;
    end else if (s1_zero) begin
      word = '0;
    end else if (s1_sign) begin
      word = ~pos_word + {{(N-1){1'b0}}, 1'b1};
    end else begin
      word = pos_word;
    end
  end

endmodule
